// File: rtl/mv_step_tracker.sv
// mv_step_tracker: per-macroblock motion-vector walker fed by the SAD minimum
// detector. Each accepted result strobe either moves the search centre and
// requests another step, or ends the search and reports the final vector.
module mv_step_tracker #(
    parameter int unsigned MVW      = 5,
    parameter int unsigned RANGE    = 7,
    parameter int unsigned STEP     = 1,
    parameter int unsigned MAX_ITER = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  res_valid,
    input  logic [3:0]            vec_diff,
    input  logic [15:0]           sad,
    output logic                  busy,
    output logic                  next_req,
    output logic                  done,
    output logic signed [MVW-1:0] mv_x,
    output logic signed [MVW-1:0] mv_y,
    output logic [15:0]           best_sad,
    output logic [7:0]            iter,
    output logic                  err
);

    // One extra bit so centre + step cannot wrap before clamping.
    localparam int unsigned SW = MVW + 1;
    localparam logic signed [SW-1:0] RANGE_P = SW'(RANGE);
    localparam logic signed [SW-1:0] RANGE_N = -RANGE_P;
    localparam logic signed [SW-1:0] STEP_S  = SW'(STEP);
    localparam logic [7:0]           ITER_LAST = 8'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  next_q, next_d;
    logic                  done_q, done_d;
    logic signed [MVW-1:0] mvx_q, mvx_d;
    logic signed [MVW-1:0] mvy_q, mvy_d;
    logic [15:0]           best_q, best_d;
    logic [7:0]            iter_q, iter_d;
    logic                  err_q, err_d;

    logic [1:0]            w_fld, h_fld;
    logic signed [SW-1:0]  dx, dy;
    logic signed [SW-1:0]  cur_x, cur_y;
    logic signed [SW-1:0]  sum_x, sum_y;
    logic signed [SW-1:0]  nx, ny;
    logic                  illegal;
    logic                  centre;
    logic                  no_imp;
    logic                  stuck;
    logic                  last;
    logic                  stop;

    // Decode the winning offset and form the clamped candidate centre.
    always_comb begin
        w_fld = vec_diff[3:2];
        h_fld = vec_diff[1:0];
        dx = '0;
        dy = '0;
        case (w_fld)
            2'd0:    dx = -STEP_S;
            2'd2:    dx = STEP_S;
            default: dx = '0;
        endcase
        case (h_fld)
            2'd0:    dy = -STEP_S;
            2'd2:    dy = STEP_S;
            default: dy = '0;
        endcase
        illegal = (w_fld == 2'd3) || (h_fld == 2'd3);
        cur_x   = {mvx_q[MVW-1], mvx_q};
        cur_y   = {mvy_q[MVW-1], mvy_q};
        sum_x   = cur_x + dx;
        sum_y   = cur_y + dy;
        nx      = (sum_x > RANGE_P) ? RANGE_P : ((sum_x < RANGE_N) ? RANGE_N : sum_x);
        ny      = (sum_y > RANGE_P) ? RANGE_P : ((sum_y < RANGE_N) ? RANGE_N : sum_y);
        centre  = (dx == '0) && (dy == '0);
        no_imp  = (sad >= best_q);
        stuck   = (nx == cur_x) && (ny == cur_y);
        last    = ((iter_q + 8'd1) == ITER_LAST);
        stop    = centre || no_imp || stuck || last;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        next_d  = 1'b0;
        done_d  = 1'b0;
        mvx_d   = mvx_q;
        mvy_d   = mvy_q;
        best_d  = best_q;
        iter_d  = iter_q;
        err_d   = err_q;
        if (start) begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
            mvx_d   = '0;
            mvy_d   = '0;
            best_d  = 16'hFFFF;
            iter_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (res_valid) begin
                        iter_d = iter_q + 8'd1;
                        err_d  = err_q | illegal;
                        if (stop) begin
                            // A non-improving SAD never overwrites the best.
                            if (sad < best_q) begin
                                best_d = sad;
                            end
                            state_d = S_FIN;
                        end else begin
                            mvx_d   = nx[MVW-1:0];
                            mvy_d   = ny[MVW-1:0];
                            best_d  = sad;
                            next_d  = 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            next_q  <= 1'b0;
            done_q  <= 1'b0;
            mvx_q   <= '0;
            mvy_q   <= '0;
            best_q  <= 16'hFFFF;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            next_q  <= next_d;
            done_q  <= done_d;
            mvx_q   <= mvx_d;
            mvy_q   <= mvy_d;
            best_q  <= best_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    assign busy     = busy_q;
    assign next_req = next_q;
    assign done     = done_q;
    assign mv_x     = mvx_q;
    assign mv_y     = mvy_q;
    assign best_sad = best_q;
    assign iter     = iter_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mv_step_tracker.sv
// Bench for mv_step_tracker: three instances (default, RANGE=2, MAX_ITER=2)
// share one directed stimulus stream and are each checked every cycle
// against a per-instance search model, plus literal spot checks.
module tb_mv_step_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        res_valid;
    logic [3:0]  vec_diff;
    logic [15:0] sad;

    logic        busy_o [3];
    logic        next_o [3];
    logic        done_o [3];
    logic        err_o  [3];
    logic [4:0]  mvx_o  [3];
    logic [4:0]  mvy_o  [3];
    logic [15:0] best_o [3];
    logic [7:0]  iter_o [3];

    mv_step_tracker #(.MVW(5), .RANGE(7), .STEP(1), .MAX_ITER(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
        .vec_diff(vec_diff), .sad(sad), .busy(busy_o[0]), .next_req(next_o[0]),
        .done(done_o[0]), .mv_x(mvx_o[0]), .mv_y(mvy_o[0]), .best_sad(best_o[0]),
        .iter(iter_o[0]), .err(err_o[0]));

    mv_step_tracker #(.MVW(5), .RANGE(2), .STEP(1), .MAX_ITER(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
        .vec_diff(vec_diff), .sad(sad), .busy(busy_o[1]), .next_req(next_o[1]),
        .done(done_o[1]), .mv_x(mvx_o[1]), .mv_y(mvy_o[1]), .best_sad(best_o[1]),
        .iter(iter_o[1]), .err(err_o[1]));

    mv_step_tracker #(.MVW(5), .RANGE(7), .STEP(1), .MAX_ITER(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .res_valid(res_valid),
        .vec_diff(vec_diff), .sad(sad), .busy(busy_o[2]), .next_req(next_o[2]),
        .done(done_o[2]), .mv_x(mvx_o[2]), .mv_y(mvy_o[2]), .best_sad(best_o[2]),
        .iter(iter_o[2]), .err(err_o[2]));

    always #5 clk = ~clk;

    // Search model state per instance.
    int rng [3] = '{7, 2, 7};
    int mit [3] = '{8, 8, 2};
    int m_mvx [3];
    int m_mvy [3];
    int m_best[3];
    int m_iter[3];
    bit m_busy[3];
    bit m_next[3];
    bit m_done[3];
    bit m_err [3];
    bit m_srch[3];
    bit m_fin [3];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic int clampv(int v, int r);
        if (v > r) return r;
        if (v < -r) return -r;
        return v;
    endfunction

    function automatic int dec(logic [1:0] f);
        if (f == 2'd2) return 1;
        if (f == 2'd0) return -1;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            m_next[i] = 1'b0;
            m_done[i] = 1'b0;
            if (!rst_n) begin
                m_busy[i] = 0; m_srch[i] = 0; m_fin[i] = 0;
                m_mvx[i] = 0; m_mvy[i] = 0; m_best[i] = 65535;
                m_iter[i] = 0; m_err[i] = 0;
            end else if (start) begin
                m_busy[i] = 1; m_srch[i] = 1; m_fin[i] = 0;
                m_mvx[i] = 0; m_mvy[i] = 0; m_best[i] = 65535;
                m_iter[i] = 0; m_err[i] = 0;
            end else if (m_fin[i]) begin
                m_done[i] = 1; m_busy[i] = 0; m_fin[i] = 0;
            end else if (m_srch[i] && res_valid) begin
                logic [3:0] v;
                int dx, dy, nx, ny, s;
                bit stop;
                v  = vec_diff;
                s  = int'(sad);
                dx = dec(v[3:2]);
                dy = dec(v[1:0]);
                if (v[3:2] == 2'd3 || v[1:0] == 2'd3) m_err[i] = 1;
                nx = clampv(m_mvx[i] + dx, rng[i]);
                ny = clampv(m_mvy[i] + dy, rng[i]);
                stop = (dx == 0 && dy == 0) || (s >= m_best[i]) ||
                       (nx == m_mvx[i] && ny == m_mvy[i]) || (m_iter[i] + 1 == mit[i]);
                m_iter[i] = m_iter[i] + 1;
                if (stop) begin
                    if (s < m_best[i]) m_best[i] = s;
                    m_srch[i] = 0;
                    m_fin[i]  = 1;
                end else begin
                    m_mvx[i]  = nx;
                    m_mvy[i]  = ny;
                    m_best[i] = s;
                    m_next[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of every instance against the model.
    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_busy[i]));
            chk($sformatf("next_req[%0d]", i), int'(next_o[i]), int'(m_next[i]));
            chk($sformatf("done[%0d]", i), int'(done_o[i]), int'(m_done[i]));
            chk($sformatf("err[%0d]", i), int'(err_o[i]), int'(m_err[i]));
            chk($sformatf("mv_x[%0d]", i), int'($signed(mvx_o[i])), m_mvx[i]);
            chk($sformatf("mv_y[%0d]", i), int'($signed(mvy_o[i])), m_mvy[i]);
            chk($sformatf("best_sad[%0d]", i), int'(best_o[i]), m_best[i]);
            chk($sformatf("iter[%0d]", i), int'(iter_o[i]), m_iter[i]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(logic [3:0] v, int s);
        res_valid = 1'b1;
        vec_diff  = v;
        sad       = 16'(s);
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; res_valid = 1'b0; vec_diff = 4'b0101; sad = '0;
        repeat (2) tick();
        chk("reset best_sad", int'(best_o[0]), 65535);
        chk("reset busy", int'(busy_o[0]), 0);
        rst_n = 1'b1;
        // Strobe while idle is ignored.
        strobe(4'b1010, 10);
        chk("idle strobe ignored iter", int'(iter_o[0]), 0);

        // Centre wins on the first step.
        pulse_start();
        chk("busy after start", int'(busy_o[0]), 1);
        strobe(4'b0101, 300);
        chk("centre no next_req", int'(next_o[0]), 0);
        chk("centre no early done", int'(done_o[0]), 0);
        tick();
        chk("centre done", int'(done_o[0]), 1);
        chk("centre busy low", int'(busy_o[0]), 0);
        chk("centre best", int'(best_o[0]), 300);
        chk("centre iter", int'(iter_o[0]), 1);
        repeat (2) tick();

        // Diagonal walk; RANGE=2 instance clamps, MAX_ITER=2 instance stops early.
        pulse_start();
        strobe(4'b1010, 500);
        chk("walk1 mv_x", int'($signed(mvx_o[0])), 1);
        chk("walk1 next", int'(next_o[0]), 1);
        tick();
        strobe(4'b1010, 400);
        chk("walk2 mv_y", int'($signed(mvy_o[0])), 2);
        chk("maxiter stop no next", int'(next_o[2]), 0);
        tick();
        chk("maxiter done", int'(done_o[2]), 1);
        chk("maxiter best", int'(best_o[2]), 400);
        strobe(4'b1010, 300);
        chk("walk3 mv_x", int'($signed(mvx_o[0])), 3);
        chk("clamp stop no next", int'(next_o[1]), 0);
        chk("clamp mv_x", int'($signed(mvx_o[1])), 2);
        tick();
        strobe(4'b0101, 300);
        tick();
        chk("walk done", int'(done_o[0]), 1);
        chk("walk final mv_y", int'($signed(mvy_o[0])), 3);
        chk("walk final best", int'(best_o[0]), 300);
        chk("walk final iter", int'(iter_o[0]), 4);
        repeat (2) tick();

        // Negative walk into the clamp.
        pulse_start();
        strobe(4'b0000, 90);
        tick();
        strobe(4'b0000, 80);
        chk("neg mv_x", int'($signed(mvx_o[1])), -2);
        tick();
        strobe(4'b0000, 70);
        chk("neg clamp no next", int'(next_o[1]), 0);
        chk("neg A mv_y", int'($signed(mvy_o[0])), -3);
        tick();
        chk("neg clamp done", int'(done_o[1]), 1);
        chk("neg clamp mv_y", int'($signed(mvy_o[1])), -2);
        chk("neg clamp best", int'(best_o[1]), 70);
        repeat (2) tick();

        // No-improvement termination.
        pulse_start();
        strobe(4'b1001, 200);
        chk("noimp mv_x", int'($signed(mvx_o[0])), 1);
        tick();
        strobe(4'b0001, 250);
        tick();
        chk("noimp done", int'(done_o[0]), 1);
        chk("noimp mv_x final", int'($signed(mvx_o[0])), 1);
        chk("noimp best", int'(best_o[0]), 200);
        repeat (2) tick();

        // Illegal field values.
        pulse_start();
        strobe(4'b1101, 100);
        chk("illegal err", int'(err_o[0]), 1);
        tick();
        chk("illegal done", int'(done_o[0]), 1);
        repeat (3) tick();
        chk("err sticky", int'(err_o[0]), 1);
        pulse_start();
        chk("err cleared", int'(err_o[0]), 0);
        strobe(4'b0111, 120);
        repeat (3) tick();

        // start coincident with res_valid mid-search, then run to MAX_ITER.
        pulse_start();
        strobe(4'b1010, 500);
        start = 1'b1; res_valid = 1'b1; vec_diff = 4'b1010; sad = 16'd400;
        tick();
        start = 1'b0; res_valid = 1'b0;
        chk("restart iter", int'(iter_o[2]), 0);
        chk("restart mv_x", int'($signed(mvx_o[2])), 0);
        tick();
        strobe(4'b1010, 300);
        tick();
        strobe(4'b1010, 200);
        tick();
        chk("maxiter2 done", int'(done_o[2]), 1);
        chk("maxiter2 iter", int'(iter_o[2]), 2);

        // start while in FIN suppresses done; back-to-back strobes.
        pulse_start();
        strobe(4'b0101, 10);
        pulse_start();
        chk("abort fin no done", int'(done_o[0]), 0);
        strobe(4'b1010, 50);
        strobe(4'b1010, 40);
        chk("b2b mv_x", int'($signed(mvx_o[0])), 2);
        strobe(4'b0101, 40);
        repeat (3) tick();

        // Asynchronous reset mid-search.
        pulse_start();
        strobe(4'b1010, 60);
        rst_n = 1'b0;
        model_step();
        #1;
        check_all();
        chk("async rst next_req", int'(next_o[0]), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        strobe(4'b0101, 5);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
